// File: rtl/manch_tx_framer.sv
// Manchester line transmitter: frames one parallel word per valid/ready handshake as
// optional alternating preamble, Manchester-coded payload, then an idle gap.
//
// state  | meaning
// S_IDLE | line at IDLE_LEVEL, tx_ready high, waiting for a word
// S_PRE  | sending alternating 1,0,... preamble bits
// S_DATA | sending payload bits from the shift register
// S_GAP  | line at IDLE_LEVEL for GAP_HALVES cells before the next word
module manch_tx_framer #(
  parameter int CLK_FREQ      = 18_750_000,
  parameter int BAUDRATE      = 115200,
  parameter int DATA_W        = 8,
  parameter int PREAMBLE_BITS = 8,
  parameter int GAP_HALVES    = 4,
  parameter bit MSB_FIRST     = 1'b0,
  parameter bit IEEE_MODE     = 1'b1,
  parameter bit IDLE_LEVEL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_manch,
  output logic              busy
);

  localparam int HALF    = CLK_FREQ / (2 * BAUDRATE);
  localparam int HALF_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_MAX = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int GAP_W   = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BIT_W-1:0]  PRE_LAST  = BIT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_HALVES - 1);

  if (HALF < 1) begin : g_bad_half
    $error("manch_tx_framer: CLK_FREQ/(2*BAUDRATE) must be at least 1");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("manch_tx_framer: DATA_W must be 1..32");
  end
  if (PREAMBLE_BITS < 0 || PREAMBLE_BITS > 255) begin : g_bad_pre
    $error("manch_tx_framer: PREAMBLE_BITS must be 0..255");
  end
  if (GAP_HALVES < 1 || GAP_HALVES > 255) begin : g_bad_gap
    $error("manch_tx_framer: GAP_HALVES must be 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                manch_q, manch_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  logic                cell_end;
  logic                cur_bit;
  logic [DATA_W-1:0]   shift_next;

  function automatic logic first_cell(input logic b);
    return IEEE_MODE ? ~b : b;
  endfunction

  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  assign cell_end   = (half_q == HALF_LAST);
  assign shift_next = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
  // preamble starts with 1, so even bit indices carry 1
  assign cur_bit    = (state_q == S_PRE) ? ~bit_q[0] : head_bit(shift_q);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    manch_d = manch_q;
    ready_d = ready_q;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        half_d  = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        gap_d   = '0;
        manch_d = IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (PREAMBLE_BITS > 0) begin
            state_d = S_PRE;
            manch_d = first_cell(1'b1);
          end else begin
            state_d = S_DATA;
            manch_d = first_cell(head_bit(tx_data));
          end
        end
      end

      S_PRE: begin
        half_d = cell_end ? '0 : half_q + 1'b1;
        if (cell_end) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            manch_d = ~first_cell(cur_bit);
          end else begin
            phase_d = 1'b0;
            if (bit_q == PRE_LAST) begin
              state_d = S_DATA;
              bit_d   = '0;
              manch_d = first_cell(head_bit(shift_q));
            end else begin
              bit_d   = bit_q + 1'b1;
              manch_d = first_cell(bit_q[0]);
            end
          end
        end
      end

      S_DATA: begin
        half_d = cell_end ? '0 : half_q + 1'b1;
        if (cell_end) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            manch_d = ~first_cell(cur_bit);
          end else begin
            phase_d = 1'b0;
            if (bit_q == DATA_LAST) begin
              state_d = S_GAP;
              bit_d   = '0;
              gap_d   = '0;
              manch_d = IDLE_LEVEL;
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_next;
              manch_d = first_cell(head_bit(shift_next));
            end
          end
        end
      end

      S_GAP: begin
        half_d  = cell_end ? '0 : half_q + 1'b1;
        manch_d = IDLE_LEVEL;
        if (cell_end) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
            half_d  = '0;
            gap_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        manch_d = IDLE_LEVEL;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      manch_q <= IDLE_LEVEL;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      manch_q <= manch_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_manch = manch_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_manch_tx_framer.sv
// Directed bench for manch_tx_framer: three configurations (IEEE, G.E. Thomas,
// preamble + MSB first), all with a 4-cycle half-bit cell.
module tb_manch_tx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_a = '0, data_b = '0, data_c = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic       ready_a, ready_b, ready_c;
  logic       manch_a, manch_b, manch_c;
  logic       busy_a, busy_b, busy_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  manch_tx_framer #(.CLK_FREQ(8), .BAUDRATE(1), .DATA_W(8), .PREAMBLE_BITS(0), .GAP_HALVES(4),
                    .MSB_FIRST(1'b0), .IEEE_MODE(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_manch(manch_a), .busy(busy_a));

  manch_tx_framer #(.CLK_FREQ(8), .BAUDRATE(1), .DATA_W(8), .PREAMBLE_BITS(0), .GAP_HALVES(4),
                    .MSB_FIRST(1'b0), .IEEE_MODE(1'b0), .IDLE_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_manch(manch_b), .busy(busy_b));

  manch_tx_framer #(.CLK_FREQ(8), .BAUDRATE(1), .DATA_W(8), .PREAMBLE_BITS(4), .GAP_HALVES(4),
                    .MSB_FIRST(1'b1), .IEEE_MODE(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .clk(clk), .rst(rst), .tx_data(data_c), .tx_valid(valid_c),
    .tx_ready(ready_c), .tx_manch(manch_c), .busy(busy_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [8:0] obs;
    logic [5:0] rb;
    rst = 1'b1;
    #2;
    obs = {manch_a, ready_a, busy_a, manch_b, ready_b, busy_b, manch_c, ready_c, busy_c};
    tests++;
    if (obs !== 9'b0) begin
      fails++; $display("FAIL reset_outputs: got %b expected %b", obs, 9'b0);
    end
    tick;
    obs = {manch_a, ready_a, busy_a, manch_b, ready_b, busy_b, manch_c, ready_c, busy_c};
    tests++;
    if (obs !== 9'b0) begin
      fails++; $display("FAIL reset_held: got %b expected %b", obs, 9'b0);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ready_a !== 1'b0) begin
      fails++; $display("FAIL ready_before_edge: got %b expected 0", ready_a);
    end
    tick;
    rb = {ready_a, ready_b, ready_c, busy_a, busy_b, busy_c};
    tests++;
    if (rb !== 6'b111000) begin
      fails++; $display("FAIL ready_after_release: got %b expected 111000", rb);
    end
  endtask

  task automatic test_ieee_frame;
    logic [15:0] cells;
    logic        exp_m;
    cells = 16'b0110_0110_1001_1001;
    data_a = 8'hA5; valid_a = 1'b1;
    tick;
    valid_a = 1'b0;
    for (int k = 0; k < 80; k++) begin
      exp_m = (k < 64) ? cells[15 - k/4] : 1'b0;
      tests++;
      if (manch_a !== exp_m || busy_a !== 1'b1 || ready_a !== 1'b0) begin
        fails++;
        $display("FAIL ieee_a5 cycle %0d: manch/busy/ready got %b%b%b expected %b10",
                 k, manch_a, busy_a, ready_a, exp_m);
      end
      tick;
    end
    tests++;
    if ({manch_a, busy_a, ready_a} !== 3'b001) begin
      fails++; $display("FAIL ieee_a5_end: manch/busy/ready got %b%b%b expected 001",
                        manch_a, busy_a, ready_a);
    end
  endtask

  task automatic test_thomas_frame;
    logic [15:0] cells;
    logic        exp_m;
    cells = 16'b1001_1001_0110_0110;
    tests++;
    if (manch_b !== 1'b0) begin
      fails++; $display("FAIL thomas_idle_level: got %b expected 0", manch_b);
    end
    data_b = 8'hA5; valid_b = 1'b1;
    tick;
    valid_b = 1'b0;
    for (int k = 0; k < 80; k++) begin
      exp_m = (k < 64) ? cells[15 - k/4] : 1'b0;
      tests++;
      if (manch_b !== exp_m || busy_b !== 1'b1 || ready_b !== 1'b0) begin
        fails++;
        $display("FAIL thomas_a5 cycle %0d: manch/busy/ready got %b%b%b expected %b10",
                 k, manch_b, busy_b, ready_b, exp_m);
      end
      tick;
    end
    tests++;
    if ({manch_b, busy_b, ready_b} !== 3'b001) begin
      fails++; $display("FAIL thomas_a5_end: manch/busy/ready got %b%b%b expected 001",
                        manch_b, busy_b, ready_b);
    end
  endtask

  task automatic test_preamble;
    logic [23:0] cells;
    logic        exp_m;
    int          busy_cnt;
    cells = 24'b01_10_01_10_01_10_10_10_10_10_10_10;
    busy_cnt = 0;
    data_c = 8'h80; valid_c = 1'b1;
    tick;
    valid_c = 1'b0;
    for (int k = 0; k < 112; k++) begin
      exp_m = (k < 96) ? cells[23 - k/4] : 1'b0;
      if (busy_c === 1'b1) busy_cnt++;
      tests++;
      if (manch_c !== exp_m || ready_c !== 1'b0) begin
        fails++;
        $display("FAIL preamble_80 cycle %0d: manch/ready got %b%b expected %b0",
                 k, manch_c, ready_c, exp_m);
      end
      tick;
    end
    tests++;
    if ({manch_c, busy_c, ready_c} !== 3'b001) begin
      fails++; $display("FAIL preamble_end: manch/busy/ready got %b%b%b expected 001",
                        manch_c, busy_c, ready_c);
    end
    tests++;
    if (busy_cnt != 112) begin
      fails++; $display("FAIL preamble_busy_len: got %0d cycles expected 112", busy_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] cells1, cells2;
    logic        exp_m;
    cells1 = 16'b0110_1010_1010_1010;
    cells2 = 16'b1001_1010_1010_1010;
    data_a = 8'h01; valid_a = 1'b1;
    tick;
    data_a = 8'h02;
    for (int k = 0; k < 80; k++) begin
      exp_m = (k < 64) ? cells1[15 - k/4] : 1'b0;
      tests++;
      if (manch_a !== exp_m || busy_a !== 1'b1 || ready_a !== 1'b0) begin
        fails++;
        $display("FAIL b2b_first cycle %0d: manch/busy/ready got %b%b%b expected %b10",
                 k, manch_a, busy_a, ready_a, exp_m);
      end
      tick;
    end
    tests++;
    if ({manch_a, busy_a, ready_a} !== 3'b001) begin
      fails++; $display("FAIL b2b_gap_end: manch/busy/ready got %b%b%b expected 001",
                        manch_a, busy_a, ready_a);
    end
    tick;
    valid_a = 1'b0;
    for (int k = 0; k < 80; k++) begin
      exp_m = (k < 64) ? cells2[15 - k/4] : 1'b0;
      tests++;
      if (manch_a !== exp_m || busy_a !== 1'b1 || ready_a !== 1'b0) begin
        fails++;
        $display("FAIL b2b_second cycle %0d: manch/busy/ready got %b%b%b expected %b10",
                 k, manch_a, busy_a, ready_a, exp_m);
      end
      tick;
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({manch_a, busy_a, ready_a} !== 3'b001) begin
        fails++; $display("FAIL b2b_no_third cycle %0d: manch/busy/ready got %b%b%b expected 001",
                          k, manch_a, busy_a, ready_a);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] cells;
    logic        exp_m;
    cells = 16'b1010_0101_0101_1010;
    data_a = 8'hA5; valid_a = 1'b1;
    tick;
    valid_a = 1'b0;
    repeat (26) tick;
    tests++;
    if (manch_a !== 1'b1 || busy_a !== 1'b1) begin
      fails++; $display("FAIL mid_frame_before_rst: manch/busy got %b%b expected 11", manch_a, busy_a);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({manch_a, ready_a, busy_a} !== 3'b000) begin
      fails++; $display("FAIL rst_async_outputs: manch/ready/busy got %b%b%b expected 000",
                        manch_a, ready_a, busy_a);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if (ready_a !== 1'b0) begin
      fails++; $display("FAIL rst_release_ready: got %b expected 0", ready_a);
    end
    tick;
    tests++;
    if ({manch_a, busy_a, ready_a} !== 3'b001) begin
      fails++; $display("FAIL rst_first_edge: manch/busy/ready got %b%b%b expected 001",
                        manch_a, busy_a, ready_a);
    end
    data_a = 8'h3C; valid_a = 1'b1;
    tick;
    valid_a = 1'b0;
    for (int k = 0; k < 80; k++) begin
      exp_m = (k < 64) ? cells[15 - k/4] : 1'b0;
      tests++;
      if (manch_a !== exp_m || busy_a !== 1'b1 || ready_a !== 1'b0) begin
        fails++;
        $display("FAIL after_rst_3c cycle %0d: manch/busy/ready got %b%b%b expected %b10",
                 k, manch_a, busy_a, ready_a, exp_m);
      end
      tick;
    end
    tests++;
    if ({manch_a, busy_a, ready_a} !== 3'b001) begin
      fails++; $display("FAIL after_rst_3c_end: manch/busy/ready got %b%b%b expected 001",
                        manch_a, busy_a, ready_a);
    end
  endtask

  task automatic test_ignore_while_busy;
    logic [15:0] cells;
    logic        exp_m;
    cells = 16'b1001_1001_0110_0110;
    data_a = 8'h5A; valid_a = 1'b1;
    tick;
    for (int k = 0; k < 80; k++) begin
      exp_m = (k < 64) ? cells[15 - k/4] : 1'b0;
      tests++;
      if (manch_a !== exp_m || busy_a !== 1'b1 || ready_a !== 1'b0) begin
        fails++;
        $display("FAIL ignore_busy_5a cycle %0d: manch/busy/ready got %b%b%b expected %b10",
                 k, manch_a, busy_a, ready_a, exp_m);
      end
      if (k < 78) begin
        valid_a = (k % 2 == 0);
        data_a  = 8'($urandom);
      end else begin
        valid_a = 1'b0;
      end
      tick;
    end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if ({manch_a, busy_a, ready_a} !== 3'b001) begin
        fails++; $display("FAIL ignore_busy_no_extra cycle %0d: manch/busy/ready got %b%b%b expected 001",
                          k, manch_a, busy_a, ready_a);
      end
      tick;
    end
  endtask

  initial begin
    test_reset();
    test_ieee_frame();
    test_thomas_frame();
    test_preamble();
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
